mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single 20-bit-address, 8-bit-data byte memory between two requesters:
//  port 0 = CPU core, port 1 = secondary master (video/DMA).
//  Issues at most one access per clock and returns read data to the owning port.
//  The read return is tagged through a pipeline matched to the fixed memory read latency.
//  Sits between the masters and the memory array; the array's read path is 2 registers deep.
// PARAMETERS
//  AW      20  address width (bytes)
//  DW      8   data width
//  RD_LAT  2   clocks from address on bus to valid din; range 1..4
// PORTS
//  clock     in   1   system clock, all state on posedge
//  locked    in   1   asynchronous active-low reset (0 = held in reset)
//  req0      in   1   port 0 access request, level
//  addr0     in   AW  port 0 address
//  wdata0    in   DW  port 0 write data
//  we0       in   1   port 0 write (1) / read (0)
//  ack0      out  1   port 0 access issued this cycle (1-clk pulse)
//  rvalid0   out  1   port 0 read data valid (1-clk pulse)
//  rdata0    out  DW  port 0 read data, meaningful only while rvalid0
//  req1,addr1,wdata1,we1,ack1,rvalid1,rdata1  same as port 0, for port 1
//  address   out  AW  memory address
//  dout      out  DW  memory write data
//  we        out  1   memory write strobe
//  din       in   DW  memory read data, valid RD_LAT clocks after address
// BEHAVIOUR
//  - Reset (locked=0, async): address=0, dout=0, we=0, ack*=0, rvalid*=0.
//    Reset also clears the return pipeline and sets the RR pointer (last=1).
//  - Reset mid-operation: in-flight reads are dropped; no rvalid after release.
//  - Arbitration at each posedge samples req0/req1, picks one winner W.
//  - The winner's addr/wdata/we are registered onto address/dout/we.
//    ackW=1 in the same following cycle T; the loser gets no ack.
//  - Handshake: requester holds req/addr/wdata/we stable until it sees ack.
//    req still high in the ack cycle = new request (back-to-back, 1 access/clk).
//  - Idle (no req): we=0, address and dout hold their last values, no ack.
//  - Write: we=1 for exactly cycle T; the memory commits at the end of T.
//    No rvalid is produced for a write.
//  - Read: a {valid,port} tag enters an RD_LAT-stage shift register in cycle T.
//    In cycle T+RD_LAT, rvalidP=1 and rdataP=din for tagged port P; the other port's rvalid=0.
//  - Ordering: accesses reach memory in grant order.
//    A read granted after a write to the same address returns the new data.
//  - rdata* are driven from din (registered mux stage optional; no extra latency allowed).
//  - Simultaneous req0&req1: resolved by the policy below; exactly one ack asserted.
//  - ack0 & ack1 never both 1; rvalid0 & rvalid1 never both 1.
// CONFIGURATION
//  ARB_RR_EN defined: round-robin.
//    On a conflict, grant the port not granted last; the pointer updates on every grant.
//    Max wait for a holding requester = 1 access.
//  ARB_RR_EN undefined: fixed priority, port 0 always wins a conflict.
//    Port 1 may starve under continuous port 0 traffic; the pointer logic is removed.
// TESTING
//  1 Reset: locked=0 with req0=1 -> all outputs 0; after locked=1, first ack0 the next clk.
//  2 Port0 read of 0x12345 (mem=0xA5) -> ack0 in T, address=0x12345 in T;
//    rvalid0=1 with rdata0=0xA5 at T+2; rvalid1 stays 0.
//  3 Port1 write 0x00010<=0x3C, then port1 read 0x00010 the next clk -> rdata1=0x3C, 2 clks after the read's ack.
//  4 req0 and req1 held high for 6 clks:
//    ARB_RR_EN -> acks alternate 0,1,0,1,0,1; fixed -> six ack0, no ack1.
//  5 Read issued in T, locked pulsed 0 in T+1 -> no rvalid in T+2; all outputs 0 during reset.
//  6 Interleaved reads p0@0x00001=0x11, p1@0x00002=0x22 on consecutive clks ->
//    rvalid0/0x11 then rvalid1/0x22 on consecutive clks, never overlapping.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one byte-wide memory between two masters: port 0 (CPU core) and
//   port 1 (secondary master, video/DMA). At most one access is issued per
//   clock. Read data is returned to the port that issued the read, using a
//   {valid,port} tag pipeline that matches the fixed memory read latency.
//
// Configuration macro:
//   ARB_RR_EN  defined   -> round-robin on conflicts. The port not granted
//                           last wins. The pointer follows every grant.
//              undefined -> fixed priority. Port 0 always wins a conflict.
//
// Parameters: AW address width, DW data width, RD_LAT memory read latency (1..4)
//
// Ports:
//   clock                 system clock, all state on posedge
//   locked                asynchronous active-low reset
//   req/addr/wdata/we{0,1} requester side: level request plus access attributes.
//                         Held stable until ack.
//   ack{0,1}              1-clk pulse in the cycle the access is on the memory bus
//   rvalid{0,1}           1-clk pulse when read data for that port is on din
//   rdata{0,1}            read data (din), forced to 0 while rvalid is low
//   address/dout/we       memory bus, registered
//   din                   memory read data, valid RD_LAT clocks after address
module mem_arbiter #(
    parameter int AW     = 20,
    parameter int DW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic          clock,
    input  logic          locked,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          we0,
    output logic          ack0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          we1,
    output logic          ack1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] address,
    output logic [DW-1:0] dout,
    output logic          we,
    input  logic [DW-1:0] din
);

    logic grant0;
    logic grant1;

`ifdef ARB_RR_EN
    // last_reg holds the port granted most recently.
    // Its reset value of 1 makes port 0 win the first conflict after reset.
    logic last_reg;

    always_comb begin
        grant0 = req0 & (~req1 | last_reg);
        grant1 = req1 & (~req0 | ~last_reg);
    end

    always_ff @(posedge clock or negedge locked) begin
        if (!locked) begin
            last_reg <= 1'b1;
        end else if (grant0 | grant1) begin
            last_reg <= grant1;
        end
    end
`else
    always_comb begin
        grant0 = req0;
        grant1 = req1 & ~req0;
    end
`endif

    // Memory bus and acknowledge registers
    logic [AW-1:0] address_reg, address_next;
    logic [DW-1:0] dout_reg, dout_next;
    logic          we_reg, we_next;
    logic          ack0_reg, ack1_reg;

    // When the bus is idle, address and dout hold their last values.
    // The write strobe is dropped when the bus is idle.
    always_comb begin
        address_next = address_reg;
        dout_next    = dout_reg;
        we_next      = 1'b0;
        if (grant1) begin
            address_next = addr1;
            dout_next    = wdata1;
            we_next      = we1;
        end else if (grant0) begin
            address_next = addr0;
            dout_next    = wdata0;
            we_next      = we0;
        end
    end

    always_ff @(posedge clock or negedge locked) begin
        if (!locked) begin
            address_reg <= '0;
            dout_reg    <= '0;
            we_reg      <= 1'b0;
            ack0_reg    <= 1'b0;
            ack1_reg    <= 1'b0;
        end else begin
            address_reg <= address_next;
            dout_reg    <= dout_next;
            we_reg      <= we_next;
            ack0_reg    <= grant0;
            ack1_reg    <= grant1;
        end
    end

    // Read return tag pipeline.
    // The tag is formed in the cycle the read is on the bus.
    // After RD_LAT stages, the tag lines up with the matching din.
    logic              issue_rd;
    logic [RD_LAT-1:0] tag_valid_reg, tag_valid_next;
    logic [RD_LAT-1:0] tag_port_reg, tag_port_next;

    assign issue_rd = (ack0_reg | ack1_reg) & ~we_reg;

    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_tag
        if (gi == 0) begin : g_head
            assign tag_valid_next[gi] = issue_rd;
            assign tag_port_next[gi]  = ack1_reg;
        end else begin : g_shift
            assign tag_valid_next[gi] = tag_valid_reg[gi-1];
            assign tag_port_next[gi]  = tag_port_reg[gi-1];
        end
    end

    // A reset drops every read that is still in flight.
    always_ff @(posedge clock or negedge locked) begin
        if (!locked) begin
            tag_valid_reg <= '0;
            tag_port_reg  <= '0;
        end else begin
            tag_valid_reg <= tag_valid_next;
            tag_port_reg  <= tag_port_next;
        end
    end

    assign address = address_reg;
    assign dout    = dout_reg;
    assign we      = we_reg;
    assign ack0    = ack0_reg;
    assign ack1    = ack1_reg;
    assign rvalid0 = tag_valid_reg[RD_LAT-1] & ~tag_port_reg[RD_LAT-1];
    assign rvalid1 = tag_valid_reg[RD_LAT-1] &  tag_port_reg[RD_LAT-1];
    // Read data comes straight from din, with no added latency.
    // It is gated to 0 outside the valid pulse.
    assign rdata0  = rvalid0 ? din : '0;
    assign rdata1  = rvalid1 ? din : '0;

endmodule
